// File: rtl/ctrl_bubble_pipe_if.sv
// ctrl_bubble_pipe_if: decoder/hazard-side bundle for the ID/EX control register.
// master drives the ID-stage inputs and enable; slave is the control register itself.
// No storage here; timing is defined entirely by ctrl_bubble_pipe.
interface ctrl_bubble_pipe_if #(
   parameter int CTRL_W     = 20,
   parameter int REG_ADDR_W = 5
);
   logic                  i_enable;
   logic [CTRL_W-1:0]     i_ctrl;
   logic [REG_ADDR_W-1:0] i_id_rs;
   logic [REG_ADDR_W-1:0] i_id_rt;
   logic                  i_id_uses_rt;
   logic                  i_flush;
   logic [CTRL_W-1:0]     o_ctrl;
   logic [REG_ADDR_W-1:0] o_ex_rt;
   logic                  o_pc_write;
   logic                  o_ifid_write;
   logic                  o_stall;
   logic                  o_halted;
   logic [31:0]           o_stall_count;

   modport master (
      output i_enable, i_ctrl, i_id_rs, i_id_rt, i_id_uses_rt, i_flush,
      input  o_ctrl, o_ex_rt, o_pc_write, o_ifid_write, o_stall, o_halted, o_stall_count
   );

   modport slave (
      input  i_enable, i_ctrl, i_id_rs, i_id_rt, i_id_uses_rt, i_flush,
      output o_ctrl, o_ex_rt, o_pc_write, o_ifid_write, o_stall, o_halted, o_stall_count
   );
endinterface

// File: rtl/ctrl_bubble_pipe.sv
// ctrl_bubble_pipe: ID/EX control-word register with load-use bubbles, branch flush and halt freeze.
// Latency: o_ctrl/o_ex_rt 1 cycle; o_pc_write/o_ifid_write/o_stall combinational.
// Backpressure: i_enable=0 holds everything; bubbles hold PC and IF/ID. Optional STALL_STATS_EN adds a bubble counter.
module ctrl_bubble_pipe #(
   parameter int CTRL_W      = 20,
   parameter int REG_ADDR_W  = 5,
   parameter int MEMREAD_BIT = 9,
   parameter int HALT_BIT    = 0,
   parameter int LOAD_STALL  = 1
) (
   input logic               i_clk,
   input logic               i_reset,
   ctrl_bubble_pipe_if.slave bus
);
   localparam int CNT_W = $clog2(LOAD_STALL + 1);
   localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_STALL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [CTRL_W-1:0]     ctrl_q, ctrl_nxt;
   logic [REG_ADDR_W-1:0] rt_q, rt_nxt;
   logic                  load_use;
   logic                  write_en;
   logic                  stall;

   // Load-use: the word now in EX is a load whose destination feeds the ID instruction.
   always_comb begin
      load_use = ctrl_q[MEMREAD_BIT] && (rt_q != '0) &&
                 ((rt_q == bus.i_id_rs) || (bus.i_id_uses_rt && (rt_q == bus.i_id_rt)));
   end

   // Next-state, next control word and front-end enables.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ctrl_nxt  = ctrl_q;
      rt_nxt    = rt_q;
      write_en  = 1'b0;
      stall     = 1'b0;
      if (bus.i_enable) begin
         case (state)
            RUN: begin
               if (bus.i_flush) begin
                  // Killing the ID instruction takes priority over stalling it.
                  ctrl_nxt = '0;
                  rt_nxt   = '0;
                  write_en = 1'b1;
               end else if (load_use) begin
                  ctrl_nxt = '0;
                  rt_nxt   = '0;
                  stall    = 1'b1;
                  if (LOAD_STALL > 1) begin
                     cnt_nxt   = STALL_INIT;
                     state_nxt = STALL;
                  end
               end else begin
                  ctrl_nxt = bus.i_ctrl;
                  rt_nxt   = bus.i_id_rt;
                  write_en = 1'b1;
                  if (bus.i_ctrl[HALT_BIT]) begin
                     state_nxt = HALTED;
                  end
               end
            end
            STALL: begin
               // Flush is ignored here: the stalled instruction has not resolved yet.
               ctrl_nxt = '0;
               stall    = 1'b1;
               cnt_nxt  = cnt - CNT_ONE;
               if (cnt == CNT_ONE) begin
                  state_nxt = RUN;
               end
            end
            HALTED: begin
               ctrl_nxt = '0;
            end
            default: begin
               state_nxt = RUN;
            end
         endcase
      end
   end

   // State, bubble counter and the ID/EX register itself.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state  <= RUN;
         cnt    <= '0;
         ctrl_q <= '0;
         rt_q   <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         ctrl_q <= ctrl_nxt;
         rt_q   <= rt_nxt;
      end
   end

   assign bus.o_ctrl       = ctrl_q;
   assign bus.o_ex_rt      = rt_q;
   assign bus.o_pc_write   = write_en;
   assign bus.o_ifid_write = write_en;
   assign bus.o_stall      = stall;
   assign bus.o_halted     = (state == HALTED);

`ifdef STALL_STATS_EN
   logic [31:0] stall_count;

   // Saturating count of inserted bubble cycles (stall already implies enable).
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
         stall_count <= stall_count + 32'd1;
      end
   end

   assign bus.o_stall_count = stall_count;
`else
   assign bus.o_stall_count = '0;
`endif
endmodule
